snake_head_stepper: RTL
=======================

Name: snake_head_stepper

Overview:
- Downstream consumer of the one-hot direction register (left/right/up/down, 0000 = no input yet).
- Advances the snake head one grid cell per move tick and rejects 180-degree reversals.
- Detects wall hits (or wraps, see Optional Feature).
- Feeds head coordinates and a step pulse to the body/collision logic and the renderer.

Parameters:
- MOVE_PERIOD, 5_000_000: clock cycles per move tick; legal range 2 or more.
- GRID_W, 32: grid columns.
- GRID_H, 24: grid rows.
- START_X, 16: head column after reset.
- START_Y, 12: head row after reset.
- Derived, not overridable: XW = $clog2(GRID_W), YW = $clog2(GRID_H), CW = $clog2(MOVE_PERIOD).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  game running; low freezes movement.
- direction  in  4  one-hot requested direction: 0001 L, 0010 R, 0100 U, 1000 D; 0000 none.
- head_x  out  XW  head column.
- head_y  out  YW  head row; 0 = top.
- cur_dir  out  4  direction actually in effect.
- step  out  1  one-cycle pulse; head moved this cycle.
- collide  out  1  sticky wall-hit flag.

Behaviour:
- Reset (async assert, sync-free release): head_x=START_X, head_y=START_Y, cur_dir=0000, pending=0000, tick counter=0, step=0, collide=0. Takes effect immediately, including mid-period.
- Tick counter:
  - Increments while enable=1 and collide=0.
  - At MOVE_PERIOD-1 it wraps to 0 and asserts the internal tick for that cycle.
  - enable=0 holds the count; it is not cleared.
- Pending direction, updated every cycle regardless of enable:
  - Loaded from direction when direction is exactly one-hot and not opposite of cur_dir.
  - 0000, multi-hot, or reversal inputs leave pending unchanged.
  - With cur_dir=0000, any one-hot input is accepted.
- On the tick edge:
  - cur_dir <= pending.
  - If pending=0000: no move, step stays 0.
  - Otherwise next cell: L x-1, R x+1, U y-1, D y+1. Head registers update on that edge and step=1 for the following cycle only.
  - Latency: a direction change accepted at least one cycle before the tick edge takes effect on that tick.
- Wall, default build:
  - The next cell leaves the grid (x=0 going L, x=GRID_W-1 going R, y=0 going U, y=GRID_H-1 going D).
  - Head holds, step=0, collide<=1.
  - collide stays 1 and movement halts until reset.
- Simultaneous events: a direction change arriving in the same cycle as the tick is not used for that tick; it applies at the next tick.
- step is never asserted while collide=1.

Optional Feature:
- Macro SNAKE_WALL_WRAP_EN.
- Defined: leaving the grid wraps to the opposite edge (x to 0 or GRID_W-1, y likewise); step pulses normally; collide is tied to 0.
- Undefined: wall behaviour as above.

Decomposition:
- Package snake_pkg:
  - DIR_NONE, DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN 4-bit constants.
  - Function dir_opposite(dir) returning the reverse one-hot.
  - Function is_onehot(dir).
- Sub-module move_tick_gen: parameter MOVE_PERIOD; ports clk, reset_n, run, tick. It owns the counter.

Test Plan (MOVE_PERIOD=4, GRID 8x8, START 4,4):
- Release reset, enable=1, direction=0010 -> first step after 4 enabled cycles, head_x=5, head_y=4; then every 4 cycles x=6, then 7.
- cur_dir=R, drive 0001 -> ignored, x keeps incrementing. Then 0100 followed by 0001 within one period -> next tick moves up (y=3); left rejected.
- Moving R at x=7 -> next tick: collide=1, x stays 7, no step; no further movement. With SNAKE_WALL_WRAP_EN: x=0, step=1, collide=0.
- enable=0 for 10 cycles at count 2 -> no step. Re-enable -> step 2 cycles later.
- Assert reset_n low mid-period with no clock edge -> outputs return to 4,4, 0000, step=0, collide=0 immediately.
- After reset, direction=0000 for 20 cycles -> no step; cur_dir stays 0000.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared direction encoding and helpers for the snake head datapath.
// Build option: define SNAKE_WALL_WRAP_EN to wrap at the grid edge.
package snake_pkg;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_LEFT  = 4'b0001;
    localparam logic [3:0] DIR_RIGHT = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

`ifdef SNAKE_WALL_WRAP_EN
    localparam bit WALL_WRAP = 1'b1;
`else
    localparam bit WALL_WRAP = 1'b0;
`endif

    function automatic logic [3:0] dir_opposite(input logic [3:0] dir);
        logic [3:0] opp;
        case (dir)
            DIR_LEFT:  opp = DIR_RIGHT;
            DIR_RIGHT: opp = DIR_LEFT;
            DIR_UP:    opp = DIR_DOWN;
            DIR_DOWN:  opp = DIR_UP;
            default:   opp = DIR_NONE;
        endcase
        return opp;
    endfunction

    function automatic logic is_onehot(input logic [3:0] dir);
        return (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Move-tick divider: one-cycle tick every MOVE_PERIOD running cycles.
// The count holds (not clears) while run is low.
module move_tick_gen #(
    parameter int MOVE_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic tick
);

    localparam int CW = $clog2(MOVE_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(MOVE_PERIOD - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);
    assign tick   = run & w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: latches a legal direction, moves one cell per tick.
// Wall hits latch collide unless SNAKE_WALL_WRAP_EN is defined (then wrap).
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int MOVE_PERIOD = 5_000_000,
    parameter int GRID_W      = 32,
    parameter int GRID_H      = 24,
    parameter int START_X     = 16,
    parameter int START_Y     = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [3:0]                direction,
    output logic [$clog2(GRID_W)-1:0] head_x,
    output logic [$clog2(GRID_H)-1:0] head_y,
    output logic [3:0]                cur_dir,
    output logic                      step,
    output logic                      collide
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    logic [3:0]    r_pending;
    logic [3:0]    r_cur_dir;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_step;
    logic          r_collide;

    logic [XW-1:0] w_nx;
    logic [YW-1:0] w_ny;
    logic          w_wall;
    logic          w_tick;
    logic          w_accept;

    move_tick_gen #(
        .MOVE_PERIOD (MOVE_PERIOD)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (enable & ~r_collide),
        .tick    (w_tick)
    );

    assign w_accept = is_onehot(direction)
                    && (direction != dir_opposite(r_cur_dir));

    // Next cell already carries the wrapped coordinate at an edge
    always_comb begin
        w_nx   = r_x;
        w_ny   = r_y;
        w_wall = 1'b0;
        unique case (1'b1)
            r_pending[0]: begin
                w_wall = (r_x == '0);
                w_nx   = w_wall ? X_MAX : r_x - XW'(1);
            end
            r_pending[1]: begin
                w_wall = (r_x == X_MAX);
                w_nx   = w_wall ? '0 : r_x + XW'(1);
            end
            r_pending[2]: begin
                w_wall = (r_y == '0);
                w_ny   = w_wall ? Y_MAX : r_y - YW'(1);
            end
            r_pending[3]: begin
                w_wall = (r_y == Y_MAX);
                w_ny   = w_wall ? '0 : r_y + YW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= DIR_NONE;
            r_cur_dir <= DIR_NONE;
            r_x       <= XW'(START_X);
            r_y       <= YW'(START_Y);
            r_step    <= 1'b0;
            r_collide <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (w_accept) begin
                r_pending <= direction;
            end
            if (w_tick) begin
                r_cur_dir <= r_pending;
                if (r_pending != DIR_NONE) begin
                    if (w_wall && !WALL_WRAP) begin
                        r_collide <= 1'b1;
                    end else begin
                        r_x    <= w_nx;
                        r_y    <= w_ny;
                        r_step <= 1'b1;
                    end
                end
            end
        end
    end

    assign head_x  = r_x;
    assign head_y  = r_y;
    assign cur_dir = r_cur_dir;
    assign step    = r_step;
    assign collide = r_collide;

endmodule
